// File: rtl/uart_tx_ctrl.sv
// Bus-programmable transmit controller: a 4-byte FIFO that feeds a UART transmitter,
// with a register map for status, control and sent-byte count, plus a level interrupt.
module uart_tx_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic       rd_en,
  input  logic [1:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       irq
);

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_SENT   = 2'd3;

  logic [7:0] mem [4];
  logic [1:0] rd_ptr;
  logic [1:0] wr_ptr;
  logic [2:0] level;
  logic [7:0] sent;
  logic       ovf;
  logic       en;
  logic       irq_en;

  logic       data_wr;
  logic       ctrl_wr;
  logic       sent_wr;
  logic       push;
  logic       drop;
  logic       pop;
  logic       empty;
  logic       full;
  logic [2:0] level_nxt;
  logic [7:0] sent_nxt;
  logic       ovf_nxt;
  logic       en_nxt;
  logic       irq_en_nxt;
  logic [7:0] status;
  logic [7:0] rd_mux;

  assign empty    = (level == 3'd0);
  assign full     = (level == 3'd4);
  assign tx_valid = en && !empty;
  assign tx_data  = mem[rd_ptr];

  always_comb begin
    data_wr    = wr_en && (addr == ADDR_DATA);
    ctrl_wr    = wr_en && (addr == ADDR_CTRL);
    sent_wr    = wr_en && (addr == ADDR_SENT);
    // Fullness is judged on the level at the start of the cycle, so a
    // concurrent pop never makes room for a write into a full FIFO.
    push       = data_wr && !full;
    drop       = data_wr && full;
    pop        = tx_ready && tx_valid;

    level_nxt = level;
    if (push && !pop)
      level_nxt = level + 3'd1;
    else if (pop && !push)
      level_nxt = level - 3'd1;

    sent_nxt = sent;
    if (sent_wr)
      sent_nxt = 8'h00;
    else if (pop)
      sent_nxt = sent + 8'd1;

    ovf_nxt = ovf;
    if (drop)
      ovf_nxt = 1'b1;
    else if (ctrl_wr && wdata[7])
      ovf_nxt = 1'b0;

    en_nxt     = ctrl_wr ? wdata[0] : en;
    irq_en_nxt = ctrl_wr ? wdata[1] : irq_en;

    status = {1'b0, level, ovf, tx_valid, empty, full};

    case (addr)
      ADDR_STATUS: rd_mux = status;
      ADDR_CTRL:   rd_mux = {6'b0, irq_en, en};
      ADDR_SENT:   rd_mux = sent;
      default:     rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) mem[i] <= 8'h00;
      rd_ptr <= 2'd0;
      wr_ptr <= 2'd0;
      level  <= 3'd0;
      sent   <= 8'h00;
      ovf    <= 1'b0;
      en     <= 1'b0;
      irq_en <= 1'b0;
      rdata  <= 8'h00;
      irq    <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 2'd1;
      level  <= level_nxt;
      sent   <= sent_nxt;
      ovf    <= ovf_nxt;
      en     <= en_nxt;
      irq_en <= irq_en_nxt;
      if (rd_en)
        rdata <= rd_mux;
      irq <= irq_en_nxt && ((level_nxt == 3'd0) || ovf_nxt);
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: a queue-based model predicts transmitted bytes,
// read data, tx_valid and irq; an independent negedge monitor compares them.
module tb_uart_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [1:0] addr = 2'd0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic       irq;

  uart_tx_ctrl dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
    .wdata(wdata), .rdata(rdata), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .irq(irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // reference model state
  logic [7:0] m_fifo[$];
  logic [7:0] m_sent;
  logic       m_ovf, m_en, m_irq_en, m_irq;
  // scoreboard queues and values the monitor compares against
  logic [7:0] tx_exp[$];
  logic [7:0] rd_q[$];
  logic       cur_txv, cur_irq;
  logic [7:0] last_rd;
  logic       rd_pend;
  logic       in_reset = 1'b1;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%02h required=%02h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_read(input logic [1:0] a);
    int sz;
    logic [2:0] lv;
    logic txv;
    sz = m_fifo.size();
    lv = sz[2:0];
    txv = m_en && (sz != 0);
    case (a)
      2'd1:    return {1'b0, lv, m_ovf, txv, (sz == 0), (sz == 4)};
      2'd2:    return {6'b0, m_irq_en, m_en};
      2'd3:    return m_sent;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    m_fifo.delete(); tx_exp.delete(); rd_q.delete();
    m_sent = 8'h00; m_ovf = 1'b0; m_en = 1'b0; m_irq_en = 1'b0; m_irq = 1'b0;
    cur_txv = 1'b0; cur_irq = 1'b0; last_rd = 8'h00; rd_pend = 1'b0;
  endtask

  // One bus/transmitter cycle: drive inputs, log expectations, advance the model.
  task automatic cyc(input logic w, input logic r, input logic [1:0] a,
                     input logic [7:0] d, input logic t);
    bit pop, push, drop;
    @(posedge clk); #1;
    wr_en = w; rd_en = r; addr = a; wdata = d; tx_ready = t;
    cur_txv = m_en && (m_fifo.size() != 0);
    cur_irq = m_irq;
    if (r) rd_q.push_back(model_read(a));
    pop  = t && cur_txv;
    push = w && (a == 2'd0) && (m_fifo.size() < 4);
    drop = w && (a == 2'd0) && (m_fifo.size() == 4);
    if (pop) begin
      void'(m_fifo.pop_front());
      m_sent = m_sent + 8'd1;
    end
    if (push) begin
      m_fifo.push_back(d);
      tx_exp.push_back(d);
    end
    if (w && a == 2'd2) begin
      m_en = d[0];
      m_irq_en = d[1];
      if (d[7]) m_ovf = 1'b0;
    end
    if (drop) m_ovf = 1'b1;
    if (w && a == 2'd3) m_sent = 8'h00;
    m_irq = m_irq_en && ((m_fifo.size() == 0) || m_ovf);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 2'd0, 8'h00, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    in_reset = 1'b1;
    wr_en = 0; rd_en = 0; addr = 2'd0; wdata = 8'h00; tx_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
    chk("rst_irq", {7'b0, irq}, 8'h00);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_rdata", rdata, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    tx_ready = 1'b0;
    rst_n = 1'b1;
    in_reset = 1'b0;
  endtask

  // monitor: samples mid-cycle, pops scoreboard entries when the DUT presents them
  always @(negedge clk) begin
    if (!in_reset) begin
      chk("tx_valid", {7'b0, tx_valid}, {7'b0, cur_txv});
      chk("irq", {7'b0, irq}, {7'b0, cur_irq});
      if (tx_valid && tx_ready) begin
        if (tx_exp.size() == 0) begin
          total++; bad++;
          $display("FAIL tx_extra actual=%02h required=none", tx_data);
        end else
          chk("tx_byte", tx_data, tx_exp.pop_front());
      end
      if (rd_pend) begin
        if (rd_q.size() == 0) begin
          total++; bad++;
          $display("FAIL rd_queue actual=%02h required=none", rdata);
        end else begin
          last_rd = rd_q.pop_front();
          chk("rdata", rdata, last_rd);
        end
      end else
        chk("rdata_hold", rdata, last_rd);
      rd_pend = rd_en;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic w, r, t;
    logic [1:0] a;
    logic [7:0] d;
    int k;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // empty after reset
    cyc(0, 1, 2'd1, 8'h00, 0);
    idle(1);

    // basic send of two bytes, then SENT
    cyc(1, 0, 2'd2, 8'h01, 0);
    cyc(1, 0, 2'd0, 8'hA5, 0);
    cyc(1, 0, 2'd0, 8'h3C, 0);
    idle(1);
    cyc(0, 0, 2'd0, 8'h00, 1);
    idle(1);
    cyc(0, 0, 2'd0, 8'h00, 1);
    cyc(0, 1, 2'd3, 8'h00, 0);
    idle(1);

    // overflow with EN=0, clear, drain
    cyc(1, 0, 2'd2, 8'h00, 0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 2'd0, 8'h10 + 8'(i), 0);
    cyc(0, 1, 2'd1, 8'h00, 0);
    cyc(1, 0, 2'd2, 8'h81, 0);
    for (int i = 0; i < 4; i++) begin cyc(0, 0, 2'd0, 8'h00, 1); idle(1); end
    cyc(0, 1, 2'd1, 8'h00, 0);

    // full FIFO, push and pop together: pop taken, byte dropped
    for (int i = 0; i < 4; i++) cyc(1, 0, 2'd0, 8'h20 + 8'(i), 0);
    cyc(1, 0, 2'd0, 8'h55, 1);
    cyc(0, 1, 2'd1, 8'h00, 0);
    cyc(1, 1, 2'd2, 8'h81, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 2'd0, 8'h00, 1);

    // level 2 with concurrent push/pop, pointer wrap
    cyc(1, 0, 2'd0, 8'h60, 0);
    cyc(1, 0, 2'd0, 8'h61, 0);
    for (int i = 0; i < 6; i++) cyc(1, 1, 2'd0, 8'h62 + 8'(i), 1);
    cyc(0, 1, 2'd1, 8'h00, 0);
    for (int i = 0; i < 2; i++) cyc(0, 0, 2'd0, 8'h00, 1);

    // irq on drain, then reset mid-queue
    cyc(1, 0, 2'd2, 8'h03, 0);
    cyc(1, 0, 2'd0, 8'h77, 0);
    cyc(0, 0, 2'd0, 8'h00, 1);
    idle(2);
    cyc(1, 0, 2'd0, 8'h78, 0);
    cyc(1, 0, 2'd0, 8'h79, 0);
    do_reset();
    cyc(0, 1, 2'd1, 8'h00, 0);
    idle(1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      k = $urandom_range(0, 99);
      w = (k < 45);
      r = ($urandom_range(0, 2) == 0);
      k = $urandom_range(0, 9);
      a = (k < 6) ? 2'd0 : (k < 7) ? 2'd1 : (k < 9) ? 2'd2 : 2'd3;
      d = 8'($urandom);
      if (a == 2'd2) d[0] = ($urandom_range(0, 99) < 85);
      t = ($urandom_range(0, 2) == 0);
      cyc(w, r, a, d, t);
    end

    // drain what remains and confirm the scoreboard emptied
    cyc(1, 0, 2'd2, 8'h81, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 2'd0, 8'h00, 1);
    cyc(0, 1, 2'd3, 8'h00, 0);
    idle(2);
    chk("tx_left", 8'(tx_exp.size()), 8'h00);
    chk("rd_left", 8'(rd_q.size()), 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
